// File: rtl/rs_pkg.sv
// Shared RS(255,239) definitions: code parameters, symbol type and GF(2^8) helpers.
package rs_pkg;

    localparam int unsigned RS_N         = 255;
    localparam int unsigned RS_K         = 239;
    localparam int unsigned RS_NSYM      = RS_N - RS_K;
    localparam logic [8:0]  RS_PRIM_POLY = 9'h11D;
    localparam int unsigned RS_FCR       = 0;

    typedef logic [7:0] gf_sym_t;

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } syn_state_t;

    // Multiply by alpha (x), reducing by the field polynomial.
    function automatic gf_sym_t gf_xtime(gf_sym_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? RS_PRIM_POLY[7:0] : 8'h00);
    endfunction

    // alpha^k; exponent taken modulo the multiplicative group order.
    function automatic gf_sym_t gf_alpha_pow(int unsigned k);
        gf_sym_t r;
        r = 8'h01;
        for (int unsigned n = 0; n < (k % RS_N); n++) begin
            r = gf_xtime(r);
        end
        return r;
    endfunction

    // General shift-and-add multiply; not used by the datapath.
    function automatic gf_sym_t gf_mul(gf_sym_t a, gf_sym_t b);
        gf_sym_t p;
        gf_sym_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Combinational multiply of a GF(2^8) symbol by the constant alpha^K.
module gf_const_mul
    import rs_pkg::*;
#(
    parameter int unsigned K = 0
) (
    input  logic [7:0] sym,
    output logic [7:0] prod
);

    // Column j of the constant matrix is alpha^K * alpha^j.
    function automatic logic [7:0][7:0] col_table(gf_sym_t c);
        logic [7:0][7:0] t;
        gf_sym_t         v;
        v = c;
        for (int j = 0; j < 8; j++) begin
            t[j] = v;
            v    = gf_xtime(v);
        end
        return t;
    endfunction

    localparam logic [7:0][7:0] Cols = col_table(gf_alpha_pow(K));

    // XOR together the columns selected by the set bits of the input.
    always_comb begin
        prod = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (sym[j]) prod = prod ^ Cols[j];
        end
    end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome calculator: Horner accumulation of S_i = r(alpha^(FCR+i)).
module rs_syndrome_calc
    import rs_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             code_in,
    input  logic                   en,
    input  logic                   decode_start,
    output logic [8*RS_NSYM-1:0]   syndromes,
    output logic                   syn_valid,
    output logic                   err_flag,
    output logic                   frame_abort,
    output logic                   busy
);

    localparam logic [7:0] LastCnt = 8'(RS_N - 1);

    syn_state_t                    state_q;
    logic [7:0]                    cnt_q;
    logic [RS_NSYM-1:0][7:0]       acc_q;
    logic [RS_NSYM-1:0][7:0]       acc_scaled;
    logic [RS_NSYM-1:0][7:0]       acc_next;

    for (genvar i = 0; i < RS_NSYM; i++) begin : g_mul
        gf_const_mul #(
            .K(RS_FCR + i)
        ) u_mul (
            .sym (acc_q[i]),
            .prod(acc_scaled[i])
        );
    end

    // One Horner step per accumulator: acc * alpha^(FCR+i) + symbol.
    always_comb begin
        acc_next = '0;
        for (int i = 0; i < RS_NSYM; i++) begin
            acc_next[i] = acc_scaled[i] ^ code_in;
        end
    end

    // Frame FSM, symbol counter, accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            acc_q       <= '0;
            syndromes   <= '0;
            syn_valid   <= 1'b0;
            err_flag    <= 1'b0;
            frame_abort <= 1'b0;
            busy        <= 1'b0;
        end else begin
            syn_valid   <= 1'b0;
            frame_abort <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (en && decode_start) begin
                        acc_q   <= {RS_NSYM{code_in}};
                        cnt_q   <= 8'd1;
                        state_q <= StAccum;
                        busy    <= 1'b1;
                    end
                end
                StAccum: begin
                    if (en) begin
                        if (decode_start) begin
                            // Restart: drop the partial frame, this symbol opens a new one.
                            frame_abort <= 1'b1;
                            acc_q       <= {RS_NSYM{code_in}};
                            cnt_q       <= 8'd1;
                        end else if (cnt_q == LastCnt) begin
                            syndromes <= acc_next;
                            err_flag  <= |acc_next;
                            syn_valid <= 1'b1;
                            cnt_q     <= 8'd0;
                            state_q   <= StIdle;
                            busy      <= 1'b0;
                        end else begin
                            acc_q <= acc_next;
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc with a direct-evaluation syndrome model.
module tb_rs_syndrome_calc;
    import rs_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   code_in;
    logic         en;
    logic         decode_start;
    logic [127:0] syndromes;
    logic         syn_valid;
    logic         err_flag;
    logic         frame_abort;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int abort_cnt = 0;

    gf_sym_t      frame [RS_N];
    gf_sym_t      gen   [RS_NSYM+1];
    logic [127:0] hist_syn [$];
    logic         hist_err [$];

    rs_syndrome_calc dut (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code_in),
        .en          (en),
        .decode_start(decode_start),
        .syndromes   (syndromes),
        .syn_valid   (syn_valid),
        .err_flag    (err_flag),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (syn_valid) begin
            valid_cnt++;
            hist_syn.push_back(syndromes);
            hist_err.push_back(err_flag);
        end
        if (frame_abort) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic feed(input int from, input int to, input bit start);
        for (int j = from; j <= to; j++) begin
            tick();
            en           = 1'b1;
            code_in      = frame[j];
            decode_start = start && (j == from);
        end
    endtask

    task automatic go_idle();
        tick();
        en           = 1'b0;
        decode_start = 1'b0;
    endtask

    task automatic build_gen();
        gf_sym_t root;
        for (int k = 0; k <= RS_NSYM; k++) gen[k] = 8'h00;
        gen[0] = 8'h01;
        for (int i = 0; i < RS_NSYM; i++) begin
            root = gf_alpha_pow(RS_FCR + i);
            for (int k = i + 1; k >= 1; k--) gen[k] = gen[k-1] ^ gf_mul(gen[k], root);
            gen[0] = gf_mul(gen[0], root);
        end
    endtask

    // Systematic encode: data then remainder of m(x)*x^16 / g(x).
    task automatic build_codeword(input int seed);
        gf_sym_t rg [RS_NSYM];
        gf_sym_t fb;
        for (int k = 0; k < RS_NSYM; k++) rg[k] = 8'h00;
        for (int j = 0; j < RS_K; j++) begin
            frame[j] = 8'((j * seed + 7) & 255);
            fb = frame[j] ^ rg[RS_NSYM-1];
            for (int k = RS_NSYM - 1; k >= 1; k--) rg[k] = rg[k-1] ^ gf_mul(fb, gen[k]);
            rg[0] = gf_mul(fb, gen[0]);
        end
        for (int t = 0; t < RS_NSYM; t++) frame[RS_K + t] = rg[RS_NSYM-1-t];
    endtask

    // Direct polynomial evaluation at alpha^(FCR+i); first symbol has degree N-1.
    function automatic logic [127:0] ref_syn();
        logic [127:0] r;
        gf_sym_t      s;
        r = '0;
        for (int i = 0; i < RS_NSYM; i++) begin
            s = 8'h00;
            for (int j = 0; j < RS_N; j++) begin
                if (frame[j] != 8'h00)
                    s = s ^ gf_mul(frame[j], gf_alpha_pow((RS_FCR + i) * (RS_N - 1 - j)));
            end
            r[8*i +: 8] = s;
        end
        return r;
    endfunction

    initial begin
        int           c0;
        int           v0;
        int           a0;
        logic [127:0] exp_syn;

        rst = 1'b1; en = 1'b0; decode_start = 1'b0; code_in = 8'h00;
        build_gen();
        tick();
        tick();
        rst = 1'b0;
        chk("reset_syndromes", syndromes, '0);
        chk("reset_syn_valid", syn_valid, 0);
        chk("reset_err_flag", err_flag, 0);
        chk("reset_frame_abort", frame_abort, 0);
        chk("reset_busy", busy, 0);

        // All-zero frame, start on symbol 0.
        for (int j = 0; j < RS_N; j++) frame[j] = 8'h00;
        c0 = cyc;
        feed(0, 254, 1'b1);
        chk("zero_busy", busy, 1);
        go_idle();
        chk("zero_latency", 128'(cyc - c0), 128'(256));
        chk("zero_valid", syn_valid, 1);
        chk("zero_syn", syndromes, '0);
        chk("zero_err", err_flag, 0);
        chk("zero_busy_done", busy, 0);
        tick();
        chk("zero_valid_pulse", syn_valid, 0);

        // Valid codeword.
        build_codeword(37);
        feed(0, 254, 1'b1);
        go_idle();
        chk("cw_valid", syn_valid, 1);
        chk("cw_syn", syndromes, '0);
        chk("cw_err", err_flag, 0);

        // Back-to-back: last symbol 0x5A, then first symbol 0x01, zero gap.
        hist_syn.delete();
        hist_err.delete();
        for (int j = 0; j < RS_N; j++) frame[j] = 8'h00;
        frame[254] = 8'h5A;
        feed(0, 254, 1'b1);
        frame[254] = 8'h00;
        frame[0]   = 8'h01;
        exp_syn    = ref_syn();
        feed(0, 254, 1'b1);
        go_idle();
        chk("b2b_count", 128'(hist_syn.size()), 128'(2));
        chk("b2b_5a_syn", hist_syn[0], {RS_NSYM{8'h5A}});
        chk("b2b_5a_err", hist_err[0], 1);
        chk("first1_s0", syndromes[7:0], 8'h01);
        chk("first1_s1", syndromes[15:8], 8'h8E);
        chk("first1_s2", syndromes[23:16], 8'h47);
        chk("first1_s3", syndromes[31:24], 8'hAD);
        chk("first1_all", syndromes, exp_syn);
        chk("first1_err", err_flag, 1);

        // Codeword with a 10-cycle stall after symbol 100; decode_start during stall is ignored.
        build_codeword(53);
        a0 = abort_cnt;
        c0 = cyc;
        feed(0, 100, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            en           = 1'b0;
            decode_start = (k == 3);
            code_in      = 8'hFF;
            chk("stall_busy", busy, 1);
        end
        feed(101, 254, 1'b0);
        go_idle();
        chk("stall_latency", 128'(cyc - c0), 128'(266));
        chk("stall_valid", syn_valid, 1);
        chk("stall_syn", syndromes, '0);
        chk("stall_err", err_flag, 0);
        chk("stall_no_abort", 128'(abort_cnt - a0), 128'(0));

        // Restart at symbol 100 with a corrupted codeword.
        frame[17]  = frame[17] ^ 8'h33;
        frame[200] = frame[200] ^ 8'h04;
        exp_syn    = ref_syn();
        a0 = abort_cnt;
        v0 = valid_cnt;
        feed(0, 99, 1'b1);
        feed(0, 254, 1'b1);
        chk("restart_no_early_valid", 128'(valid_cnt - v0), 128'(0));
        go_idle();
        chk("restart_abort", 128'(abort_cnt - a0), 128'(1));
        chk("restart_valid", syn_valid, 1);
        chk("restart_syn", syndromes, exp_syn);
        chk("restart_err", err_flag, 1);

        // Reset at symbol 50.
        feed(0, 49, 1'b1);
        tick();
        rst = 1'b1;
        en  = 1'b1;
        tick();
        rst = 1'b0;
        en  = 1'b0;
        chk("midrst_syn", syndromes, '0);
        chk("midrst_valid", syn_valid, 0);
        chk("midrst_err", err_flag, 0);
        chk("midrst_busy", busy, 0);
        v0 = valid_cnt;
        feed(0, 254, 1'b0);
        go_idle();
        tick();
        chk("nostart_no_valid", 128'(valid_cnt - v0), 128'(0));
        chk("nostart_busy", busy, 0);
        feed(0, 254, 1'b1);
        go_idle();
        chk("after_rst_valid", syn_valid, 1);
        chk("after_rst_syn", syndromes, exp_syn);
        chk("after_rst_err", err_flag, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
